eth_mac_rx_fcs_check: RTL and testbench

//  RX-side FCS checker/stripper. Sits between the RX byte deframer (preamble/SFD removed) and the RX FIFO.
//  - Runs Ethernet CRC-32 over every byte of a frame, FCS included, and compares the result to the residue.
//  - Removes the 4 FCS bytes through a 4-byte delay line and tags the last payload byte good or bad.
//  - Also flags length and PHY errors, and keeps a saturating count of bad frames.

---
 rtl/eth_mac_pkg.sv | 14 +
 rtl/eth_rx_fcs_delay.sv | 35 +++
 rtl/eth_mac_rx_fcs_check.sv | 96 +++++++++
 tb/tb_eth_mac_rx_fcs_check.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/eth_mac_pkg.sv
// eth_mac_pkg: Ethernet MAC shared CRC-32 constants and byte-step function.
package eth_mac_pkg;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
  // Unreflected register, data bits fed LSB first (wire order)
  function automatic logic [31:0] crc32_d8(input logic [7:0] data, input logic [31:0] crc);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = (c[31] ^ data[i]) ? {c[30:0], 1'b0} ^ CRC32_POLY : {c[30:0], 1'b0};
    return c;
  endfunction
endpackage

// File: rtl/eth_rx_fcs_delay.sv
// eth_rx_fcs_delay: byte shift register with fill count; holds back the trailing DEPTH bytes of a frame.
module eth_rx_fcs_delay #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic [W-1:0] head_o
);
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);
  logic [W-1:0]  sr_q [DEPTH];
  logic [FW-1:0] fill_q;
  assign full_o = fill_q == FULL;
  assign head_o = sr_q[DEPTH-1];
  // clear_i drops the held bytes without shifting; they are the FCS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else if (push_i) begin
      if (clear_i) begin
        fill_q <= '0;
      end else begin
        sr_q[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
        fill_q <= full_o ? fill_q : fill_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/eth_mac_rx_fcs_check.sv
// eth_mac_rx_fcs_check: RX FCS check and strip; tags the last payload byte good/bad and reports frame status.
module eth_mac_rx_fcs_check
  import eth_mac_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             in_err,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_bad,
  output logic             stat_valid,
  output logic             stat_crc,
  output logic             stat_len,
  output logic             stat_phy,
  output logic [CNT_W-1:0] stat_bytes,
  output logic [CNT_W-1:0] err_cnt
);
  localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] RUNT  = CNT_W'(4);
  logic [31:0]      crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, len_d, bytes_q, err_cnt_q;
  logic             phy_q, phy_d, crc_err, len_err, bad, frame_end, full;
  logic [7:0]       head, data_q;
  logic             valid_q, last_q, bad_q, sv_q, sc_q, sl_q, sp_q;
  eth_rx_fcs_delay #(.DEPTH(4), .W(8)) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .clear_i (in_last),
    .data_i  (in_data),
    .full_o  (full),
    .head_o  (head)
  );
  // crc_q is reloaded with the init value at every frame end, so a new frame never sees stale state
  always_comb begin
    crc_d     = crc32_d8(in_data, crc_q);
    len_d     = &cnt_q ? cnt_q : cnt_q + 1'b1;
    phy_d     = phy_q | in_err;
    crc_err   = crc_d != CRC32_RESIDUE;
    len_err   = len_d <= RUNT | len_d < MIN_L | len_d > MAX_L;
    frame_end = in_valid & in_last;
    bad       = crc_err | len_err | phy_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q     <= CRC32_INIT;
      cnt_q     <= '0;
      phy_q     <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      bad_q     <= 1'b0;
      sv_q      <= 1'b0;
      sc_q      <= 1'b0;
      sl_q      <= 1'b0;
      sp_q      <= 1'b0;
      bytes_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      valid_q <= in_valid & full;
      data_q  <= head;
      last_q  <= frame_end & full;
      bad_q   <= frame_end & full & bad;
      sv_q    <= frame_end;
      sc_q    <= frame_end & crc_err;
      sl_q    <= frame_end & len_err;
      sp_q    <= frame_end & phy_d;
      bytes_q <= frame_end ? len_d : '0;
      if (in_valid) begin
        crc_q <= in_last ? CRC32_INIT : crc_d;
        cnt_q <= in_last ? '0 : len_d;
        phy_q <= ~in_last & phy_d;
      end
      if (frame_end & bad & ~&err_cnt_q) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_last   = last_q;
  assign out_bad    = bad_q;
  assign stat_valid = sv_q;
  assign stat_crc   = sc_q;
  assign stat_len   = sl_q;
  assign stat_phy   = sp_q;
  assign stat_bytes = bytes_q;
  assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_eth_mac_rx_fcs_check.sv
// tb_eth_mac_rx_fcs_check: directed frames into two checkers (MIN_LEN=0 and default) with immediate-assert checks.
module tb_eth_mac_rx_fcs_check;
  logic clk = 1'b0, rst_n = 1'b1, iv = 1'b0, il = 1'b0, ie = 1'b0;
  logic [7:0] idt = 8'h00;
  logic ov [2], ol [2], ob [2], sv [2], sc [2], sl [2], sp [2];
  logic [7:0] od [2];
  logic [15:0] sb [2], ec [2];
  always #5 clk = ~clk;
  eth_mac_rx_fcs_check #(.MIN_LEN(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_data(idt), .in_last(il), .in_err(ie),
    .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]), .out_bad(ob[0]),
    .stat_valid(sv[0]), .stat_crc(sc[0]), .stat_len(sl[0]), .stat_phy(sp[0]),
    .stat_bytes(sb[0]), .err_cnt(ec[0]));
  eth_mac_rx_fcs_check u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_data(idt), .in_last(il), .in_err(ie),
    .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]), .out_bad(ob[1]),
    .stat_valid(sv[1]), .stat_crc(sc[1]), .stat_len(sl[1]), .stat_phy(sp[1]),
    .stat_bytes(sb[1]), .err_cnt(ec[1]));
  typedef struct {bit crc; bit len; bit phy; bit wl; int bytes;} st_t;
  typedef struct {int n; bit bad;} lt_t;
  st_t sq0[$], sq1[$];
  lt_t lq0[$], lq1[$];
  logic [7:0] oq0[$], oq1[$], frm[$], pa[$], pb[$];
  int run [2];
  int total = 0, nbad = 0;
  task automatic ck(string tag, logic [63:0] o, logic [63:0] e);
    total++;
    assert (o === e) else begin
      nbad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  // reference FCS in reflected form, independent of the DUT's shift direction
  function automatic logic [31:0] fcs_of(input logic [7:0] b[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c ^= {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    return ~c;
  endfunction
  task automatic sample();
    st_t s;
    lt_t l;
    for (int d = 0; d < 2; d++) begin
      if (ov[d]) begin
        if (d == 0) oq0.push_back(od[0]); else oq1.push_back(od[1]);
        run[d]++;
        if (ol[d]) begin
          l.n = run[d];
          l.bad = ob[d];
          if (d == 0) lq0.push_back(l); else lq1.push_back(l);
          run[d] = 0;
        end
      end
      if (sv[d]) begin
        s.crc = sc[d]; s.len = sl[d]; s.phy = sp[d]; s.wl = ol[d]; s.bytes = int'(sb[d]);
        if (d == 0) sq0.push_back(s); else sq1.push_back(s);
      end
    end
  endtask
  task automatic tick();
    @(negedge clk);
    sample();
  endtask
  task automatic idle(input int n);
    iv = 1'b0; il = 1'b0; ie = 1'b0;
    repeat (n) tick();
  endtask
  task automatic send(input int err_idx, input bit gaps);
    for (int i = 0; i < frm.size(); i++) begin
      iv = 1'b1; idt = frm[i]; il = (i == frm.size() - 1); ie = (i == err_idx);
      tick();
      if (gaps && $urandom_range(0, 2) == 0) begin
        iv = 1'b0; il = 1'b0; ie = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    iv = 1'b0; il = 1'b0; ie = 1'b0;
  endtask
  task automatic build(input logic [7:0] base, input int n);
    logic [31:0] c;
    frm = {};
    for (int i = 0; i < n; i++) frm.push_back(base + 8'(i));
    c = fcs_of(frm);
    frm.push_back(c[7:0]); frm.push_back(c[15:8]); frm.push_back(c[23:16]); frm.push_back(c[31:24]);
  endtask
  task automatic chk(string tag, int d, logic [7:0] pl[$], bit ebad, bit ecrc, bit elen, bit ephy, int ebytes);
    st_t s;
    lt_t l;
    int mism = 0;
    logic [7:0] b;
    if (pl.size() > 0) begin
      ck($sformatf("%s.last_seen", tag), (d ? lq1.size() : lq0.size()) != 0, 1);
      if ((d ? lq1.size() : lq0.size()) != 0) begin
        l = d ? lq1.pop_front() : lq0.pop_front();
        ck($sformatf("%s.nout", tag), l.n, pl.size());
        ck($sformatf("%s.bad", tag), l.bad, ebad);
      end
      foreach (pl[i]) begin
        b = 8'hxx;
        if (d == 0 && oq0.size() != 0) b = oq0.pop_front();
        if (d == 1 && oq1.size() != 0) b = oq1.pop_front();
        if (b !== pl[i]) mism++;
      end
      ck($sformatf("%s.data_mism", tag), mism, 0);
    end
    ck($sformatf("%s.stat_seen", tag), (d ? sq1.size() : sq0.size()) != 0, 1);
    if ((d ? sq1.size() : sq0.size()) != 0) begin
      s = d ? sq1.pop_front() : sq0.pop_front();
      ck($sformatf("%s.crc", tag), s.crc, ecrc);
      ck($sformatf("%s.len", tag), s.len, elen);
      ck($sformatf("%s.phy", tag), s.phy, ephy);
      ck($sformatf("%s.bytes", tag), s.bytes, ebytes);
      ck($sformatf("%s.with_last", tag), s.wl, pl.size() > 0);
    end
  endtask
  initial begin
    #1 rst_n = 1'b0;
    tick();
    for (int d = 0; d < 2; d++)
      ck($sformatf("reset%0d", d), {ov[d], ol[d], ob[d], sv[d], sc[d], sl[d], sp[d], od[d], sb[d], ec[d]}, 0);
    rst_n = 1'b1;
    idle(2);
    // 1: "123456789" with known FCS
    frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
    pa = frm[0:8];
    ck("ref_fcs", fcs_of(pa), 32'hCBF43926);
    send(-1, 0);
    idle(2);
    chk("t1_min0", 0, pa, 0, 0, 0, 0, 13);
    chk("t1_dflt", 1, pa, 1, 0, 1, 0, 13);
    ck("t1_err0", ec[0], 0);
    ck("t1_err1", ec[1], 1);
    // 2: corrupted FCS byte
    frm[12] = 8'hCA;
    send(-1, 0);
    idle(2);
    chk("t2_min0", 0, pa, 1, 1, 0, 0, 13);
    chk("t2_dflt", 1, pa, 1, 1, 1, 0, 13);
    ck("t2_err0", ec[0], 1);
    ck("t2_err1", ec[1], 2);
    // 3: exactly minimum length, then one byte short
    build(8'h00, 60);
    pa = frm[0:59];
    send(-1, 0);
    idle(2);
    chk("t3_64_dflt", 1, pa, 0, 0, 0, 0, 64);
    chk("t3_64_min0", 0, pa, 0, 0, 0, 0, 64);
    build(8'h00, 59);
    pa = frm[0:58];
    send(-1, 0);
    idle(2);
    chk("t3_63_dflt", 1, pa, 1, 0, 1, 0, 63);
    chk("t3_63_min0", 0, pa, 0, 0, 0, 0, 63);
    ck("t3_err0", ec[0], 1);
    ck("t3_err1", ec[1], 3);
    // 4: runt
    frm = {8'hAA, 8'hBB, 8'hCC};
    pa = {};
    send(-1, 0);
    idle(2);
    chk("t4_min0", 0, pa, 0, 1, 1, 0, 3);
    chk("t4_dflt", 1, pa, 0, 1, 1, 0, 3);
    ck("t4_nout0", oq0.size(), 0);
    ck("t4_nout1", oq1.size(), 0);
    ck("t4_err0", ec[0], 2);
    ck("t4_err1", ec[1], 4);
    // 5: back-to-back with gaps, PHY error on byte 10 of the second frame
    build(8'h10, 60);
    pa = frm[0:59];
    send(-1, 1);
    build(8'h90, 60);
    pb = frm[0:59];
    send(10, 1);
    idle(2);
    chk("t5a_dflt", 1, pa, 0, 0, 0, 0, 64);
    chk("t5b_dflt", 1, pb, 1, 0, 0, 1, 64);
    chk("t5a_min0", 0, pa, 0, 0, 0, 0, 64);
    chk("t5b_min0", 0, pb, 1, 0, 0, 1, 64);
    ck("t5_err0", ec[0], 3);
    ck("t5_err1", ec[1], 5);
    // 6: reset after 20 bytes, then a good frame
    build(8'h40, 60);
    for (int i = 0; i < 20; i++) begin
      iv = 1'b1; idt = frm[i]; il = 1'b0; ie = 1'b0;
      tick();
    end
    iv = 1'b0;
    rst_n = 1'b0;
    tick();
    ck("t6_rst_out", {ov[0], ov[1], sv[0], sv[1], ec[0], ec[1]}, 0);
    rst_n = 1'b1;
    tick();
    ck("t6_no_stat", sq0.size() + sq1.size(), 0);
    ck("t6_no_last", lq0.size() + lq1.size(), 0);
    oq0 = {}; oq1 = {}; run[0] = 0; run[1] = 0;
    build(8'h80, 60);
    pa = frm[0:59];
    send(-1, 0);
    idle(2);
    chk("t6_dflt", 1, pa, 0, 0, 0, 0, 64);
    chk("t6_min0", 0, pa, 0, 0, 0, 0, 64);
    ck("t6_err0", ec[0], 0);
    ck("t6_err1", ec[1], 0);
    ck("leftover", oq0.size() + oq1.size() + sq0.size() + sq1.size() + lq0.size() + lq1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
